// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared types for the WISC decode-stage hazard unit: the encoded stall
// cause reported to the decode logic and the branch-wait FSM state.
package hazard_pkg;

  // Reported stall reason; the encoding is visible on the stall_cause port.
  typedef enum logic [1:0] {
    HZ_NONE     = 2'd0,
    HZ_RAW      = 2'd1,
    HZ_LOAD_USE = 2'd2,
    HZ_BR_FLAG  = 2'd3
  } stall_cause_t;

  // IDLE: data hazards and branch detection active.
  // BR_WAIT: holding a branch until the flag writer ahead of it clears EX.
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_BR_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_match.sv
// hazard_match
// Compares one pipeline stage's pending destination register against every
// ID source slot and raises a single hit when any enabled slot matches.
// Register 0 never matches.
// Ports:
//   id_valid  in  ID holds a real instruction
//   src_regs  in  packed source registers, slot i at [i*REG_AW +: REG_AW]
//   src_en    in  per-slot read enable
//   dst       in  stage destination register
//   wrt       in  stage writes its destination
//   hit       out any enabled slot matches a live, non-zero destination
module hazard_match #(
  parameter int REG_AW  = 4,
  parameter int NUM_SRC = 2
) (
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] src_regs,
  input  logic [NUM_SRC-1:0]        src_en,
  input  logic [REG_AW-1:0]         dst,
  input  logic                      wrt,
  output logic                      hit
);

  logic [NUM_SRC-1:0] slot_hit;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_slot
      assign slot_hit[gi] = src_en[gi] & (src_regs[gi*REG_AW +: REG_AW] == dst);
    end
  endgenerate

  assign hit = id_valid & wrt & (dst != '0) & (|slot_hit);

endmodule

// File: rtl/hazard_unit_p.sv
// hazard_unit_p
// Decode-stage hazard detection for the WISC pipeline. Checks ID sources
// against the ID/EX, EX/MEM and MEM/WB destinations, holds a conditional
// branch for BR_STALL_CYCLES cycles while the flag writer ahead of it is in
// EX, flushes IF/ID and ID/EX on a taken branch and counts stall cycles.
// Build option: define HAZARD_FWD_EN when a forwarding network exists; then
// only ID/EX load-use matches stall.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_valid, id_rd_reg,
//   id_rd_en, id_branch,
//   id_call                    ID-stage instruction description
//   *_wb_dst, *_wrt            per-stage pending destinations
//   id_ex_mem_rd               ID/EX instruction is a load
//   id_ex_flag_wrt             ID/EX instruction writes the flags
//   ex_branch_taken            branch resolved taken in EX
//   perf_clr                   synchronous clear of stall_cnt
//   stall, flush_if_id,
//   flush_id_ex, stall_cause   combinational control outputs
//   stall_cnt                  saturating stall-cycle counter
module hazard_unit_p
  import hazard_pkg::*;
#(
  parameter int REG_AW          = 4,
  parameter int NUM_SRC         = 2,
  parameter int BR_STALL_CYCLES = 1,
  parameter int CNT_W           = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_rd_reg,
  input  logic [NUM_SRC-1:0]        id_rd_en,
  input  logic                      id_branch,
  input  logic                      id_call,
  input  logic [REG_AW-1:0]         id_ex_wb_dst,
  input  logic [REG_AW-1:0]         ex_mem_wb_dst,
  input  logic [REG_AW-1:0]         mem_wb_dst,
  input  logic                      id_ex_wrt,
  input  logic                      ex_mem_wrt,
  input  logic                      mem_wb_wrt,
  input  logic                      id_ex_mem_rd,
  input  logic                      id_ex_flag_wrt,
  input  logic                      ex_branch_taken,
  input  logic                      perf_clr,
  output logic                      stall,
  output logic                      flush_if_id,
  output logic                      flush_id_ex,
  output logic [1:0]                stall_cause,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int BR_W = $clog2(BR_STALL_CYCLES + 1);
  localparam logic [BR_W-1:0] BR_LOAD = BR_W'(BR_STALL_CYCLES - 1);

  hz_state_t         state_reg, state_next;
  logic [BR_W-1:0]   br_cnt_reg, br_cnt_next;
  logic [CNT_W-1:0]  stall_cnt_reg;

  // Stage 0 = ID/EX, 1 = EX/MEM, 2 = MEM/WB.
  logic [REG_AW-1:0] stage_dst [3];
  logic [2:0]        stage_wrt;
  logic [2:0]        stage_hit;

  assign stage_dst[0] = id_ex_wb_dst;
  assign stage_dst[1] = ex_mem_wb_dst;
  assign stage_dst[2] = mem_wb_dst;
  assign stage_wrt    = {mem_wb_wrt, ex_mem_wrt, id_ex_wrt};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_stage
      hazard_match #(
        .REG_AW  (REG_AW),
        .NUM_SRC (NUM_SRC)
      ) u_match (
        .id_valid (id_valid),
        .src_regs (id_rd_reg),
        .src_en   (id_rd_en),
        .dst      (stage_dst[gi]),
        .wrt      (stage_wrt[gi]),
        .hit      (stage_hit[gi])
      );
    end
  endgenerate

  logic load_use;
  logic raw;

  assign load_use = stage_hit[0] & id_ex_mem_rd;

`ifdef HAZARD_FWD_EN
  // Forwarding covers every non-load producer; later-stage hits are dropped.
  logic unused_fwd_hits;
  assign unused_fwd_hits = &{1'b0, stage_hit[2:1]};
  assign raw = 1'b0;
`else
  assign raw = (stage_hit[0] & ~id_ex_mem_rd) | stage_hit[1] | stage_hit[2];
`endif

  logic         br_detect;
  logic         stall_int;
  logic         flush_int;
  stall_cause_t cause_int;

  assign br_detect = id_valid & id_branch & id_ex_flag_wrt;

  always_comb begin
    state_next  = state_reg;
    br_cnt_next = br_cnt_reg;
    stall_int   = 1'b0;
    flush_int   = 1'b0;
    cause_int   = HZ_NONE;
    if (ex_branch_taken) begin
      // Taken branch squashes everything younger, including a pending wait.
      flush_int   = 1'b1;
      state_next  = ST_IDLE;
      br_cnt_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (br_detect) begin
            stall_int = 1'b1;
            cause_int = HZ_BR_FLAG;
            // The detection cycle is itself the first stall cycle.
            if (BR_STALL_CYCLES > 1) begin
              br_cnt_next = BR_LOAD;
              state_next  = ST_BR_WAIT;
            end
          end else if (!id_call) begin
            if (load_use) begin
              stall_int = 1'b1;
              cause_int = HZ_LOAD_USE;
            end else if (raw) begin
              stall_int = 1'b1;
              cause_int = HZ_RAW;
            end
          end
        end
        ST_BR_WAIT: begin
          stall_int   = 1'b1;
          cause_int   = HZ_BR_FLAG;
          br_cnt_next = br_cnt_reg - BR_W'(1);
          if (br_cnt_reg == BR_W'(1)) begin
            state_next = ST_IDLE;
          end
        end
        default: begin
          state_next  = ST_IDLE;
          br_cnt_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      br_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      br_cnt_reg <= br_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (perf_clr) begin
      stall_cnt_reg <= '0;
    end else if (stall_int && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  // Outputs are forced quiet while reset is held.
  assign stall       = rst_n & stall_int;
  assign flush_if_id = rst_n & flush_int;
  assign flush_id_ex = rst_n & flush_int;
  assign stall_cause = rst_n ? cause_int : HZ_NONE;
  assign stall_cnt   = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_unit_p.sv
module tb_hazard_unit_p;

  localparam int REG_AW  = 4;
  localparam int NUM_SRC = 2;
  localparam int BR_SC   = 3;
  localparam int CNT_W   = 4;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_rd_reg;
  logic [NUM_SRC-1:0]        id_rd_en;
  logic                      id_branch, id_call;
  logic [REG_AW-1:0]         id_ex_wb_dst, ex_mem_wb_dst, mem_wb_dst;
  logic                      id_ex_wrt, ex_mem_wrt, mem_wb_wrt;
  logic                      id_ex_mem_rd, id_ex_flag_wrt;
  logic                      ex_branch_taken, perf_clr;
  logic                      stall, flush_if_id, flush_id_ex;
  logic [1:0]                stall_cause;
  logic [CNT_W-1:0]          stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_unit_p #(
    .REG_AW          (REG_AW),
    .NUM_SRC         (NUM_SRC),
    .BR_STALL_CYCLES (BR_SC),
    .CNT_W           (CNT_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_rd_reg       (id_rd_reg),
    .id_rd_en        (id_rd_en),
    .id_branch       (id_branch),
    .id_call         (id_call),
    .id_ex_wb_dst    (id_ex_wb_dst),
    .ex_mem_wb_dst   (ex_mem_wb_dst),
    .mem_wb_dst      (mem_wb_dst),
    .id_ex_wrt       (id_ex_wrt),
    .ex_mem_wrt      (ex_mem_wrt),
    .mem_wb_wrt      (mem_wb_wrt),
    .id_ex_mem_rd    (id_ex_mem_rd),
    .id_ex_flag_wrt  (id_ex_flag_wrt),
    .ex_branch_taken (ex_branch_taken),
    .perf_clr        (perf_clr),
    .stall           (stall),
    .flush_if_id     (flush_if_id),
    .flush_id_ex     (flush_id_ex),
    .stall_cause     (stall_cause),
    .stall_cnt       (stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One line per checked cycle: stall, both flushes and cause.
  task automatic chk_out(input string tag, input logic s, input logic f, input logic [1:0] c);
    $display("%0t %s: stall=%0b flush=%0b%0b cause=%0d cnt=%0d", $time, tag,
             stall, flush_if_id, flush_id_ex, stall_cause, stall_cnt);
    chk({tag, ".stall"}, 32'(stall), 32'(s));
    chk({tag, ".flush_if_id"}, 32'(flush_if_id), 32'(f));
    chk({tag, ".flush_id_ex"}, 32'(flush_id_ex), 32'(f));
    chk({tag, ".cause"}, 32'(stall_cause), 32'(c));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_rd_reg = '0; id_rd_en = '0; id_branch = 0; id_call = 0;
    id_ex_wb_dst = '0; ex_mem_wb_dst = '0; mem_wb_dst = '0;
    id_ex_wrt = 0; ex_mem_wrt = 0; mem_wb_wrt = 0;
    id_ex_mem_rd = 0; id_ex_flag_wrt = 0; ex_branch_taken = 0; perf_clr = 0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    // Outputs must stay quiet in reset even with every trigger asserted.
    id_valid = 1; id_branch = 1; id_ex_flag_wrt = 1; ex_branch_taken = 1;
    #12;
    chk_out("reset_quiet", 0, 0, 0);
    chk("reset_cnt", 32'(stall_cnt), 0);
    clear_inputs();
    tick();
    rst_n = 1;
    tick();

    // MEM/WB hit on slot 0.
    id_valid = 1; id_rd_reg = {4'd0, 4'd5}; id_rd_en = 2'b01;
    mem_wb_wrt = 1; mem_wb_dst = 4'd5;
    settle();
    chk_out("raw_memwb", !FWD, 0, FWD ? 2'd0 : 2'd1);
    tick();

    // Register 0 never hazards.
    id_rd_reg = {4'd0, 4'd0}; mem_wb_dst = 4'd0;
    settle();
    chk_out("dst_zero", 0, 0, 0);
    tick();

    // EX/MEM hit on slot 1.
    clear_inputs();
    id_valid = 1; id_rd_reg = {4'd3, 4'd7}; id_rd_en = 2'b10;
    ex_mem_wrt = 1; ex_mem_wb_dst = 4'd3;
    settle();
    chk_out("raw_exmem_slot1", !FWD, 0, FWD ? 2'd0 : 2'd1);
    tick();

    // Slot 1 not read: no hazard.
    id_rd_en = 2'b01;
    settle();
    chk_out("slot_disabled", 0, 0, 0);
    tick();

    // Invalid ID instruction.
    id_rd_en = 2'b10; id_valid = 0;
    settle();
    chk_out("id_invalid", 0, 0, 0);
    tick();

    // Calls never stall.
    id_valid = 1; id_call = 1;
    settle();
    chk_out("call_mask", 0, 0, 0);
    tick();

    // Load-use on ID/EX.
    clear_inputs();
    id_valid = 1; id_rd_reg = {4'd0, 4'd3}; id_rd_en = 2'b01;
    id_ex_wrt = 1; id_ex_wb_dst = 4'd3; id_ex_mem_rd = 1;
    settle();
    chk_out("load_use", 1, 0, 2'd2);
    tick();

    // Bubble in ID/EX, load has moved to EX/MEM.
    id_ex_wrt = 0; id_ex_mem_rd = 0; id_ex_wb_dst = 4'd0;
    ex_mem_wrt = 1; ex_mem_wb_dst = 4'd3;
    settle();
    chk_out("load_after_bubble", !FWD, 0, FWD ? 2'd0 : 2'd1);
    tick();

    // Non-load producer in ID/EX.
    ex_mem_wrt = 0; ex_mem_wb_dst = 4'd0;
    id_ex_wrt = 1; id_ex_wb_dst = 4'd3;
    settle();
    chk_out("raw_idex_alu", !FWD, 0, FWD ? 2'd0 : 2'd1);
    tick();

    // LOAD_USE outranks RAW from MEM/WB on the other slot.
    id_rd_reg = {4'd5, 4'd3}; id_rd_en = 2'b11; id_ex_mem_rd = 1;
    mem_wb_wrt = 1; mem_wb_dst = 4'd5;
    settle();
    chk_out("prio_load_over_raw", 1, 0, 2'd2);
    tick();

    clear_inputs();
    settle();
    chk("cnt_data_section", 32'(stall_cnt), FWD ? 32'd2 : 32'd6);
    perf_clr = 1;
    tick();
    perf_clr = 0;
    chk("cnt_clear", 32'(stall_cnt), 0);

    // Branch waiting on flags: exactly 3 stall cycles, BR_FLAG beats RAW.
    id_valid = 1; id_branch = 1; id_ex_flag_wrt = 1;
    id_rd_reg = {4'd0, 4'd5}; id_rd_en = 2'b01; mem_wb_wrt = 1; mem_wb_dst = 4'd5;
    settle();
    chk_out("br_cyc1", 1, 0, 2'd3);
    tick();
    id_ex_flag_wrt = 0; mem_wb_wrt = 0;
    settle();
    chk_out("br_cyc2", 1, 0, 2'd3);
    tick();
    settle();
    chk_out("br_cyc3", 1, 0, 2'd3);
    tick();
    settle();
    chk_out("br_done", 0, 0, 0);
    chk("br_cnt3", 32'(stall_cnt), 3);
    tick();

    // Taken branch in the 2nd stall cycle aborts the wait.
    id_ex_flag_wrt = 1;
    settle();
    chk_out("brf_cyc1", 1, 0, 2'd3);
    tick();
    id_ex_flag_wrt = 0; ex_branch_taken = 1;
    settle();
    chk_out("brf_flush", 0, 1, 0);
    tick();
    ex_branch_taken = 0; id_branch = 0;
    settle();
    chk_out("brf_idle_after", 0, 0, 0);
    chk("brf_cnt", 32'(stall_cnt), 4);
    tick();

    // Detection and flush together: flush wins, no wait entered.
    id_branch = 1; id_ex_flag_wrt = 1; ex_branch_taken = 1;
    settle();
    chk_out("simul_flush", 0, 1, 0);
    tick();
    clear_inputs();
    settle();
    chk_out("simul_no_wait", 0, 0, 0);
    chk("simul_cnt", 32'(stall_cnt), 4);

    // Saturation over 20 load-use stall cycles.
    perf_clr = 1;
    tick();
    perf_clr = 0;
    chk("sat_start", 32'(stall_cnt), 0);
    id_valid = 1; id_rd_reg = {4'd0, 4'd9}; id_rd_en = 2'b01;
    id_ex_wrt = 1; id_ex_wb_dst = 4'd9; id_ex_mem_rd = 1;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_15", 32'(stall_cnt), 15);
    perf_clr = 1;
    settle();
    chk_out("clr_with_stall", 1, 0, 2'd2);
    tick();
    chk("clr_prio", 32'(stall_cnt), 0);
    perf_clr = 0;
    tick();
    chk("cnt_after_clr", 32'(stall_cnt), 1);

    // Reset in the middle of a branch wait.
    clear_inputs();
    id_valid = 1; id_branch = 1; id_ex_flag_wrt = 1;
    tick();
    clear_inputs();
    settle();
    chk_out("rst_pre_wait", 1, 0, 2'd3);
    rst_n = 0;
    ex_branch_taken = 1;
    #1;
    chk_out("rst_mid_wait", 0, 0, 0);
    chk("rst_mid_cnt", 32'(stall_cnt), 0);
    ex_branch_taken = 0;
    tick();
    rst_n = 1;
    settle();
    chk_out("rst_release_idle", 0, 0, 0);
    tick();
    settle();
    chk_out("rst_idle_next", 0, 0, 0);
    chk("rst_cnt_final", 32'(stall_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
